// File: rtl/verificador_defs.sv
// -----------------------------------------------------------------------------
// verificador_defs
//   Shared definitions for the level checker (verificador_nivel) and its
//   popcount helper: FSM state codes, the debug code shown for an illegal
//   state, and the width function for the mismatched-LED counter.
//
//   Contents:
//     estado_t            3-bit FSM state encoding (also exported on db_estado)
//     COD_INVALIDO        debug code reported for any unused state encoding
//     largura_diferencas  bits needed to hold 0 .. linhas*colunas
// -----------------------------------------------------------------------------
package verificador_defs;

    typedef enum logic [2:0] {
        OCIOSO   = 3'd0,
        BUSCA    = 3'd1,
        COMPARA  = 3'd2,
        FIM_OK   = 3'd3,
        FIM_ERRO = 3'd4
    } estado_t;

    localparam logic [2:0] COD_INVALIDO = 3'd7;

    // Width of the mismatch counter: it must represent every value from zero
    // up to one mismatch per LED of the whole board.
    function automatic int largura_diferencas(input int linhas, input int colunas);
        return $clog2(linhas * colunas + 1);
    endfunction

endpackage

// File: rtl/contador_uns.sv
// -----------------------------------------------------------------------------
// contador_uns
//   Combinational popcount: number of bits set in one board row.
//   Only present when CONTA_DIFERENCAS_EN is defined; without that macro the
//   checker stops at the first bad row and has no use for a count, so the
//   module is not compiled at all.
//
//   Parameters:
//     LARGURA  bits in the input word
//     SOMA_W   width of the count (default just wide enough for LARGURA)
//   Ports:
//     dado  in   LARGURA  word to count
//     soma  out  SOMA_W   number of ones in dado
// -----------------------------------------------------------------------------
`ifdef CONTA_DIFERENCAS_EN
module contador_uns #(
    parameter int LARGURA = 8,
    parameter int SOMA_W  = $clog2(LARGURA + 1)
) (
    input  logic [LARGURA-1:0] dado,
    output logic [SOMA_W-1:0]  soma
);

    // NOTE: blocking assignments are correct here -- inside always_comb the
    // running total must be visible to the next loop iteration immediately.
    always_comb begin
        soma = '0;
        for (int i = 0; i < LARGURA; i++) begin
            soma = soma + SOMA_W'(dado[i]);
        end
    end

endmodule
`endif

// File: rtl/verificador_nivel.sv
// -----------------------------------------------------------------------------
// verificador_nivel
//   After each player move, walks the LED-matrix board memory row by row and
//   compares it against the target-pattern memory of the current level. A
//   full match produces a one-cycle nivel_concluido pulse (together with
//   pronto) for the game control unit; any mismatch produces pronto alone.
//
//   Both memories share linha_addr and return data one cycle after the
//   address, so every row costs two cycles: busca (address out) and compara
//   (data back). A full scan reaches fim_* 2*LINHAS cycles after the start
//   edge; pronto/nivel_concluido are decoded from the fim_* state.
//
//   Build option (macro CONTA_DIFERENCAS_EN):
//     defined   - every row is scanned and diferencas accumulates the number
//                 of mismatched LEDs (for the "LEDs remaining" display).
//     undefined - the scan stops at the first mismatching row and diferencas
//                 is tied to zero.
//
//   Parameters:
//     LINHAS   rows scanned (>= 2)
//     COLUNAS  LEDs per row (bits per memory word)
//     ADDR_W   row address width, 2**ADDR_W >= LINHAS
//   Ports:
//     clock            in   1        rising-edge clock
//     reset            in   1        synchronous, active-high
//     zera             in   1        synchronous abort/clear from control unit
//     verificar        in   1        start pulse, only honoured in ocioso
//     linha_addr       out  ADDR_W   row address to both memories
//     tabuleiro_dado   in   COLUNAS  board row, one cycle after linha_addr
//     gabarito_dado    in   COLUNAS  target row, one cycle after linha_addr
//     ocupado          out  1        scan in progress (busca..fim_*)
//     pronto           out  1        one-cycle end-of-scan pulse
//     nivel_concluido  out  1        one-cycle pulse with pronto on a full match
//     diferencas       out  DIF_W    mismatched-LED count (0 without the macro)
//     db_estado        out  3        state code for debug, 7 = illegal state
// -----------------------------------------------------------------------------
module verificador_nivel
    import verificador_defs::*;
#(
    parameter int LINHAS  = 8,
    parameter int COLUNAS = 8,
    parameter int ADDR_W  = 3
) (
    input  logic                                          clock,
    input  logic                                          reset,
    input  logic                                          zera,
    input  logic                                          verificar,
    output logic [ADDR_W-1:0]                             linha_addr,
    input  logic [COLUNAS-1:0]                            tabuleiro_dado,
    input  logic [COLUNAS-1:0]                            gabarito_dado,
    output logic                                          ocupado,
    output logic                                          pronto,
    output logic                                          nivel_concluido,
    output logic [largura_diferencas(LINHAS, COLUNAS)-1:0] diferencas,
    output logic [2:0]                                    db_estado
);

    localparam int                DIF_W  = largura_diferencas(LINHAS, COLUNAS);
    localparam logic [ADDR_W-1:0] ULTIMA = ADDR_W'(LINHAS - 1);

`ifdef CONTA_DIFERENCAS_EN
    localparam bit SAIDA_ANTECIPADA = 1'b0;
`else
    localparam bit SAIDA_ANTECIPADA = 1'b1;
`endif

    estado_t             estado, estado_prox;
    logic [ADDR_W-1:0]   linha, linha_prox;
    // Remembers a mismatch in an earlier row so the last row can still pick
    // fim_erro when every row is scanned.
    logic                falha, falha_prox;
    logic [COLUNAS-1:0]  erro;
    logic                erro_linha;

    assign erro       = tabuleiro_dado ^ gabarito_dado;
    assign erro_linha = |erro;
    assign linha_addr = linha;

    // -------------------------------------------------------------------------
    // Next-state / datapath control
    // -------------------------------------------------------------------------
    // NOTE: every signal written here gets a default before the case; a path
    // that leaves one unassigned would infer a latch.
    always_comb begin
        estado_prox = estado;
        linha_prox  = linha;
        falha_prox  = falha;

        case (estado)
            OCIOSO: begin
                if (verificar) begin
                    estado_prox = BUSCA;
                    linha_prox  = '0;
                    falha_prox  = 1'b0;
                end
            end

            // Address is on linha_addr this cycle; data arrives next cycle.
            BUSCA: estado_prox = COMPARA;

            COMPARA: begin
                if (erro_linha) begin
                    falha_prox = 1'b1;
                end

                if (SAIDA_ANTECIPADA && erro_linha) begin
                    estado_prox = FIM_ERRO;
                    linha_prox  = '0;
                end else if (linha == ULTIMA) begin
                    // Last row ends the scan; linha never wraps, it is parked
                    // at zero so linha_addr reads 0 once back in ocioso.
                    estado_prox = (falha || erro_linha) ? FIM_ERRO : FIM_OK;
                    linha_prox  = '0;
                end else begin
                    estado_prox = BUSCA;
                    linha_prox  = linha + 1'b1;
                end
            end

            FIM_OK, FIM_ERRO: estado_prox = OCIOSO;

            default: begin
                estado_prox = OCIOSO;
                linha_prox  = '0;
            end
        endcase

        // Abort from the control unit overrides everything, including a start
        // request in the same cycle.
        if (zera) begin
            estado_prox = OCIOSO;
            linha_prox  = '0;
            falha_prox  = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers
    // update from the same pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            estado <= OCIOSO;
            linha  <= '0;
            falha  <= 1'b0;
        end else begin
            estado <= estado_prox;
            linha  <= linha_prox;
            falha  <= falha_prox;
        end
    end

    // -------------------------------------------------------------------------
    // Mismatch counter
    // -------------------------------------------------------------------------
`ifdef CONTA_DIFERENCAS_EN
    localparam int              POP_W   = $clog2(COLUNAS + 1);
    localparam int              SOMA_W  = DIF_W + 1;
    localparam logic [SOMA_W-1:0] DIF_MAX = SOMA_W'(LINHAS * COLUNAS);

    logic [POP_W-1:0]  uns_linha;
    logic [SOMA_W-1:0] soma;
    logic [DIF_W-1:0]  dif, dif_prox;

    contador_uns #(
        .LARGURA (COLUNAS),
        .SOMA_W  (POP_W)
    ) u_contador_uns (
        .dado (erro),
        .soma (uns_linha)
    );

    // One extra bit so the saturation compare sees a true overflow.
    assign soma = {1'b0, dif} + SOMA_W'(uns_linha);

    always_comb begin
        dif_prox = dif;
        if (estado == COMPARA) begin
            dif_prox = (soma > DIF_MAX) ? DIF_MAX[DIF_W-1:0] : soma[DIF_W-1:0];
        end
        // Value is held after the scan until the next accepted start.
        if ((estado == OCIOSO) && verificar) begin
            dif_prox = '0;
        end
        if (zera) begin
            dif_prox = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            dif <= '0;
        end else begin
            dif <= dif_prox;
        end
    end

    assign diferencas = dif;
`else
    assign diferencas = '0;
`endif

    // -------------------------------------------------------------------------
    // Outputs decoded from state
    // -------------------------------------------------------------------------
    // pronto is masked by zera so an abort landing on a fim_* cycle drops the
    // result instead of reporting it.
    always_comb begin
        ocupado         = 1'b0;
        pronto          = 1'b0;
        nivel_concluido = 1'b0;
        db_estado       = COD_INVALIDO;

        case (estado)
            OCIOSO: begin
                db_estado = OCIOSO;
            end
            BUSCA, COMPARA: begin
                ocupado   = 1'b1;
                db_estado = estado;
            end
            FIM_OK: begin
                ocupado         = 1'b1;
                pronto          = !zera;
                nivel_concluido = !zera;
                db_estado       = FIM_OK;
            end
            FIM_ERRO: begin
                ocupado   = 1'b1;
                pronto    = !zera;
                db_estado = FIM_ERRO;
            end
            default: begin
                db_estado = COD_INVALIDO;
            end
        endcase
    end

endmodule
